data_bus_master: RTL

DATA_BUS_MASTER -- requirements
Module: data_bus_master

---
 rtl/data_bus_master_pkg.sv | 20 ++
 rtl/data_bus_master_if.sv | 12 +
 rtl/data_bus_master_bus_watchdog.sv | 31 +++
 rtl/data_bus_master.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/data_bus_master_pkg.sv
// Shared definitions for the data bus master: device decode, error data, FSM states.
package data_bus_master_pkg;

    localparam logic [3:0]  DEV_MEM  = 4'h0;
    localparam logic [3:0]  DEV_FP   = 4'h1;
    localparam logic [15:0] ERR_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDLAT = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Only the memory and floating-point devices exist on this bus.
    function automatic logic dev_ok(input logic [15:0] addr);
        return (addr[15:12] == DEV_MEM) || (addr[15:12] == DEV_FP);
    endfunction

endpackage

// File: rtl/data_bus_master_if.sv
// Bus-side signals between the data bus master and its slave.
interface data_bus_master_if;
    logic        ReadData;
    logic        WriteData;
    logic [15:0] DataAddr;
    logic [15:0] BusIn;
    logic [15:0] BusOut;
    logic        Waitreq;

    modport master (output ReadData, WriteData, DataAddr, BusIn, input BusOut, Waitreq);
    modport slave  (input ReadData, WriteData, DataAddr, BusIn, output BusOut, Waitreq);
endinterface

// File: rtl/data_bus_master_bus_watchdog.sv
// Counts busy cycles of the slave and flags when the allowed wait budget is used up.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = 8'd0;
        else if (count_en)
            count_d = count_q + 8'd1;
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            count_q <= 8'd0;
        else
            count_q <= count_d;
    end

    assign expired = (count_q == LIMIT);
endmodule

// File: rtl/data_bus_master.sv
// Single-outstanding load/store master: decodes, drives the bus, waits out
// slave latency and returns load data (or an error marker) to writeback.
module data_bus_master
    import data_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RD_LAT         = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [15:0]           req_addr,
    input  logic [15:0]           req_wdata,
    input  logic [2:0]            req_rd,
    output logic                  stall,
    data_bus_master_if.master     dbus,
    output logic                  wb_valid,
    output logic [15:0]           wb_data,
    output logic [2:0]            wb_rd,
    output logic                  bus_error
);
    localparam logic [1:0] LAT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [2:0]  rd_q, rd_d;
    logic [15:0] rdata_q, rdata_d;
    logic [1:0]  lat_q, lat_d;
    logic        rd_stb_q, rd_stb_d;
    logic        wr_stb_q, wr_stb_d;
    logic        wb_valid_q, wb_valid_d;
    logic        err_q, err_d;
    logic        stall_q, stall_d;
    logic        wd_clear;
    logic        wd_expired;

    bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (wd_clear),
        .count_en ((state_q == BUS) && dbus.Waitreq),
        .expired  (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        rd_d       = rd_q;
        rdata_d    = rdata_q;
        lat_d      = lat_q;
        rd_stb_d   = 1'b0;
        wr_stb_d   = 1'b0;
        wb_valid_d = 1'b0;
        err_d      = 1'b0;
        wd_clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    rd_d    = req_rd;
                    if (dev_ok(req_addr)) begin
                        state_d  = BUS;
                        wd_clear = 1'b1;
                        rd_stb_d = !req_write;
                        wr_stb_d = req_write;
                    end else begin
                        // Unmapped device: never touch the bus, report at once.
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                        if (!req_write) begin
                            state_d    = RESP;
                            wb_valid_d = 1'b1;
                        end
                    end
                end
            end
            BUS: begin
                if (!dbus.Waitreq) begin
                    if (write_q) begin
                        state_d = IDLE;
                    end else if (RD_LAT == 0) begin
                        rdata_d    = dbus.BusOut;
                        state_d    = RESP;
                        wb_valid_d = 1'b1;
                    end else begin
                        state_d = RDLAT;
                        lat_d   = LAT_INIT;
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    if (write_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = RESP;
                        wb_valid_d = 1'b1;
                    end
                end else begin
                    rd_stb_d = !write_q;
                    wr_stb_d = write_q;
                end
            end
            RDLAT: begin
                if (lat_q == 2'd0) begin
                    rdata_d    = dbus.BusOut;
                    state_d    = RESP;
                    wb_valid_d = 1'b1;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            addr_q     <= 16'd0;
            wdata_q    <= 16'd0;
            write_q    <= 1'b0;
            rd_q       <= 3'd0;
            rdata_q    <= 16'd0;
            lat_q      <= 2'd0;
            rd_stb_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            rd_q       <= rd_d;
            rdata_q    <= rdata_d;
            lat_q      <= lat_d;
            rd_stb_q   <= rd_stb_d;
            wr_stb_q   <= wr_stb_d;
            wb_valid_q <= wb_valid_d;
            err_q      <= err_d;
            stall_q    <= stall_d;
        end
    end

    assign stall          = stall_q;
    assign dbus.ReadData  = rd_stb_q;
    assign dbus.WriteData = wr_stb_q;
    assign dbus.DataAddr  = addr_q;
    assign dbus.BusIn     = wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_data        = rdata_q;
    assign wb_rd          = rd_q;
    assign bus_error      = err_q;
endmodule
